// File: rtl/vga_timing_pipe_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_pipe_pkg
//   Shared definitions for the VGA timing pipeline:
//   - default 640x480@60 timing constant set (100 MHz clk, /4 pixel tick)
//   - sync_t: the {hs, vs, de} bundle carried through the alignment delay
//   - in_span(): half-open window test used for active area and sync pulses
//   Colour packing everywhere in this block is {r, g, b}, red in the MSBs.
// ---------------------------------------------------------------------------
package vga_timing_pipe_pkg;

  // 640x480@60 with a 25 MHz pixel rate derived from a 100 MHz clk.
  localparam int VGA_CLK_DIV  = 4;
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam int VGA_PIPE_LAT = 2;
  localparam int VGA_COLOR_W  = 4;

  // Sync flags are carried active-high; polarity is applied at the pins.
  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
  } sync_t;

  // True when lo <= val < lo + len.
  function automatic logic in_span(input int val, input int lo, input int len);
    return (val >= lo) && (val < lo + len);
  endfunction

endpackage

// File: rtl/pix_delay_line.sv
// ---------------------------------------------------------------------------
// pix_delay_line
//   Clock-enabled shift register used to align sync/blank with renderer
//   latency. DEPTH = 0 degenerates to a wire.
//   Ports:
//     clk    in   system clock
//     rst_n  in   asynchronous active-low reset, loads RST_VAL into every stage
//     ce     in   shift enable (one stage per asserted cycle)
//     d      in   W-bit input word
//     q      out  W-bit word delayed by DEPTH enabled cycles
// ---------------------------------------------------------------------------
module pix_delay_line #(
  parameter int           W       = 1,
  parameter int           DEPTH   = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ce,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_pass
      assign q = d;
      // Clock, reset and enable have no role in the pass-through case.
      logic unused_pass;
      assign unused_pass = ^{clk, rst_n, ce};
    end else begin : g_shift
      logic [W-1:0] stage [DEPTH];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
        end else if (ce) begin
          stage[0] <= d;
          for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
      end

      assign q = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_pipe.sv
// ---------------------------------------------------------------------------
// vga_timing_pipe
//   Parametrised VGA scan generator. Divides clk into a pixel tick, walks the
//   H/V raster, issues pixel-coordinate requests to a renderer, and re-aligns
//   the returned colour with delayed sync/blank so the pins stay coherent.
//   Pin state reflects the request issued PIPE_LAT+1 ticks earlier.
//   Ports:
//     clk          in   system clock
//     RSTN         in   asynchronous active-low reset
//     pix_ce       out  one-clk pixel tick
//     pix_x        out  request column (h counter)
//     pix_y        out  request row (v counter)
//     pix_valid    out  request lies in the active area
//     line_start   out  pulse with the tick that enters x = 0
//     frame_start  out  pulse with the tick that enters (0,0)
//     rgb_in       in   renderer colour {r,g,b}, PIPE_LAT ticks after request
//     vga_hs/vs    out  sync pins (HS_POL/VS_POL = active level)
//     vga_red/green/blue out colour pins, forced to 0 during blanking
// ---------------------------------------------------------------------------
module vga_timing_pipe
  import vga_timing_pipe_pkg::*;
#(
  parameter int CLK_DIV  = VGA_CLK_DIV,
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int PIPE_LAT = VGA_PIPE_LAT,
  parameter int COLOR_W  = VGA_COLOR_W,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int XW      = $clog2(H_TOTAL),
  localparam int YW      = $clog2(V_TOTAL)
) (
  input  logic                 clk,
  input  logic                 RSTN,
  output logic                 pix_ce,
  output logic [XW-1:0]        pix_x,
  output logic [YW-1:0]        pix_y,
  output logic                 pix_valid,
  output logic                 line_start,
  output logic                 frame_start,
  input  logic [3*COLOR_W-1:0] rgb_in,
  output logic                 vga_hs,
  output logic                 vga_vs,
  output logic [COLOR_W-1:0]   vga_red,
  output logic [COLOR_W-1:0]   vga_green,
  output logic [COLOR_W-1:0]   vga_blue
);

  localparam int            DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
  localparam logic [XW-1:0] H_LAST  = XW'(H_TOTAL - 1);
  localparam logic [YW-1:0] V_LAST  = YW'(V_TOTAL - 1);

  logic [DW-1:0] div;
  logic [XW-1:0] h_cnt;
  logic [YW-1:0] v_cnt;
  sync_t         raw;
  sync_t         dly;

  // Pixel tick divider. With CLK_DIV = 1, div stays 0 and the tick is constant.
  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN)                div <= '0;
    else if (div == DIV_MAX)  div <= '0;
    else                      div <= div + DW'(1);
  end

  assign pix_ce = (div == DIV_MAX);

  // Counters park at the last position of the frame so the very first tick
  // after reset lands on (0,0) and raises frame_start.
  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      h_cnt <= H_LAST;
      v_cnt <= V_LAST;
    end else if (pix_ce) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + YW'(1);
      end else begin
        h_cnt <= h_cnt + XW'(1);
      end
    end
  end

  assign pix_x       = h_cnt;
  assign pix_y       = v_cnt;
  assign pix_valid   = in_span(int'(h_cnt), 0, H_ACTIVE) && in_span(int'(v_cnt), 0, V_ACTIVE);
  assign line_start  = pix_ce && (h_cnt == H_LAST);
  assign frame_start = line_start && (v_cnt == V_LAST);

  always_comb begin
    raw    = '0;
    raw.hs = in_span(int'(h_cnt), H_ACTIVE + H_FP, H_SYNC);
    raw.vs = in_span(int'(v_cnt), V_ACTIVE + V_FP, V_SYNC);
    raw.de = pix_valid;
  end

  // Delays sync/de by the renderer latency so they meet the matching colour.
  pix_delay_line #(
    .W       ($bits(sync_t)),
    .DEPTH   (PIPE_LAT),
    .RST_VAL ('0)
  ) u_sync_dly (
    .clk   (clk),
    .rst_n (RSTN),
    .ce    (pix_ce),
    .d     (raw),
    .q     (dly)
  );

  // Pin register: one tick of latency on top of the delay line. Colour is
  // gated by de so blanking is black regardless of what the renderer returns.
  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      vga_hs    <= ~HS_POL;
      vga_vs    <= ~VS_POL;
      vga_red   <= '0;
      vga_green <= '0;
      vga_blue  <= '0;
    end else if (pix_ce) begin
      vga_hs    <= dly.hs ? HS_POL : ~HS_POL;
      vga_vs    <= dly.vs ? VS_POL : ~VS_POL;
      vga_red   <= dly.de ? rgb_in[3*COLOR_W-1 -: COLOR_W] : '0;
      vga_green <= dly.de ? rgb_in[2*COLOR_W-1 -: COLOR_W] : '0;
      vga_blue  <= dly.de ? rgb_in[COLOR_W-1   -: COLOR_W] : '0;
    end
  end

endmodule
